// File: rtl/fma16_result_q.sv
// fma16_result_q
// Result/flag capture queue placed directly after the combinational
// half-precision FMA. Captures {result, flags} pairs into a DEPTH-entry
// FIFO with first-word fall-through and maintains a sticky accrued-exception
// register that software can clear.
//
// Ports
//   clk, resetn            : clock, asynchronous active-low reset
//   in_valid/in_ready      : enqueue handshake (in_ready = not full)
//   in_result, in_flags    : binary16 result and {NV, OF, UF, NX} from FMA
//   out_valid/out_ready    : dequeue handshake (out_valid = not empty)
//   out_result, out_flags  : head entry, forced to zero when empty
//   accflags, clracc       : sticky OR of accepted flags, synchronous clear
//   count                  : current occupancy, 0..DEPTH
module fma16_result_q #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_result,
    input  logic [3:0]                 in_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_result,
    output logic [3:0]                 out_flags,
    output logic [3:0]                 accflags,
    input  logic                       clracc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [19:0]   mem_q [DEPTH];
    logic [19:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    acc_q, acc_d;

    logic enq_fire;
    logic deq_fire;
    logic [19:0] head;

    // Handshake status depends on registered occupancy only, so a dequeue
    // while full does not open in_ready in the same cycle.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign enq_fire  = in_valid & in_ready;
    assign deq_fire  = out_valid & out_ready;

    assign head       = out_valid ? mem_q[rd_ptr_q] : 20'h0_0000;
    assign out_result = head[19:4];
    assign out_flags  = head[3:0];
    assign accflags   = acc_q;
    assign count      = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (enq_fire) begin
            mem_d[wr_ptr_q] = {in_result, in_flags};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (enq_fire && !deq_fire) begin
            count_d = count_q + CW'(1);
        end else if (!enq_fire && deq_fire) begin
            count_d = count_q - CW'(1);
        end

        // A clear and a flagged enqueue in the same cycle keep the new flags.
        acc_d = (clracc ? 4'b0000 : acc_q) | (enq_fire ? in_flags : 4'b0000);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= 4'b0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    // Storage is not reset; empty masking hides stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
